playlist_sequencer: RTL and testbench
=====================================

// Module: playlist_sequencer
// PURPOSE
//  Sequences the song player through an ordered playlist. Sits between the one-pulsed front-panel
//  buttons and the MCU/song_player pair, and drives play, reset_player and song. Handles
//  play/pause, next/prev and auto-advance on song_done, with a silent gap between songs.
//  Optionally loops at the end of the list.
// PARAMETERS
//  NUM_SONGS   4   songs in the list; index range 0..NUM_SONGS-1 (need not be a power of 2)
//  SONG_W      2   width of song index; 2**SONG_W >= NUM_SONGS
//  GAP_CYCLES  8   silent cycles between song_done and the next song's load (>=1)
//  GAP_W       4   width of gap counter; 2**GAP_W > GAP_CYCLES
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  play_button   in   1       one-cycle pulse: start / pause / resume
//  next_button   in   1       one-cycle pulse: skip forward
//  prev_button   in   1       one-cycle pulse: skip back
//  loop_en       in   1       level: 1 = wrap to song 0 after the last song
//  song_done     in   1       one-cycle pulse from song player: current song finished
//  play          out  1       1 = player advances notes
//  reset_player  out  1       one-cycle pulse: player reloads from start of `song`
//  song          out  SONG_W  current playlist index
//  list_end      out  1       one-cycle pulse: playlist finished without loop
// BEHAVIOUR
//  - All outputs registered. On reset low: state=IDLE, song=0, play=0, reset_player=0,
//    list_end=0, gap counter=0. Takes effect immediately, mid-song or mid-gap included.
//  - States: IDLE, LOAD, PLAY, PAUSE, GAP. play=1 only in PLAY; reset_player=1 only in LOAD.
//  - IDLE:  play_button -> LOAD. next/prev -> change index, stay IDLE. song_done ignored.
//  - LOAD:  exactly one cycle, then PLAY. All inputs ignored.
//  - PLAY:  priority song_done > next > prev > play_button.
//           song_done -> GAP, counter = GAP_CYCLES-1.
//           next -> song+1, LOAD. prev -> song-1, LOAD. play_button -> PAUSE.
//  - PAUSE: play_button -> PLAY (no reload). next/prev -> change index, LOAD.
//           song_done ignored.
//  - GAP:   counter decrements each cycle. next_button -> song+1, LOAD immediately
//           (end-of-list check bypassed). prev_button -> song-1, LOAD. play_button ignored.
//           When counter==0 and no button:
//             - song==NUM_SONGS-1 and loop_en==0 -> IDLE, song=0, list_end=1 for one cycle.
//             - otherwise -> song+1, LOAD.
//  - Index arithmetic is modulo NUM_SONGS: (NUM_SONGS-1)+1 -> 0, 0-1 -> NUM_SONGS-1.
//    song is never outside 0..NUM_SONGS-1.
//  - loop_en is sampled only at the GAP end decision.
//  - Latency:
//    - play_button in IDLE sampled at edge N -> reset_player=1 in cycle N+1, play=1 from N+2.
//    - song_done at edge N -> play=0 from N+1. Next LOAD follows GAP_CYCLES cycles later.
//  - Simultaneous pulses are resolved by the per-state priority above. Only one index change
//    per cycle.
// TESTING
//  1. Reset low, then high; pulse play_button -> reset_player pulses 1 cycle with song=0;
//     play=1 on the following cycle.
//  2. In PLAY at song=0, pulse song_done -> play=0 for 8 cycles, then reset_player pulse
//     with song=1, then play=1.
//  3. song=3, loop_en=0, song_done -> after gap: IDLE, song=0, list_end 1-cycle pulse,
//     play stays 0. Repeat with loop_en=1 -> LOAD, song=0, play=1.
//  4. In PLAY, pulse play_button -> play=0 with no reset_player. Pulse again -> play=1,
//     song unchanged. prev_button at song=0 -> song=3, reset_player pulse.
//  5. Same-cycle song_done+next_button in PLAY -> GAP entered, song unchanged.
//     next_button during GAP -> immediate LOAD, song+1, gap aborted.
//  6. Assert reset low mid-GAP and mid-PLAY (not clock-aligned) -> outputs go to reset
//     values immediately and asynchronously; sequencer restarts from IDLE.

Source files
------------

// File: rtl/playlist_sequencer.sv
// playlist_sequencer: drives play/reset_player/song from panel buttons and song_done, with play/pause, skip, auto-advance, inter-song gap and optional loop
module playlist_sequencer #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int GAP_CYCLES = 8,
  parameter int GAP_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              loop_en,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic              list_end
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [SONG_W-1:0] LAST     = SONG_W'(NUM_SONGS - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(GAP_CYCLES - 1);
  logic [2:0]        state, state_n;
  logic [SONG_W-1:0] song_n, song_inc, song_dec;
  logic [GAP_W-1:0]  cnt, cnt_n;
  logic              end_n;
  assign song_inc = (song == LAST) ? '0 : song + 1'b1;
  assign song_dec = (song == '0) ? LAST : song - 1'b1;
  always_comb begin
    state_n = state;
    song_n  = song;
    cnt_n   = cnt;
    end_n   = 1'b0;
    case (state)
      IDLE:
        if (play_button) state_n = LOAD;
        else if (next_button) song_n = song_inc;
        else if (prev_button) song_n = song_dec;
      LOAD: state_n = PLAY;
      PLAY:
        if (song_done) begin
          state_n = GAP;
          cnt_n   = GAP_INIT;
        end else if (next_button) begin
          state_n = LOAD;
          song_n  = song_inc;
        end else if (prev_button) begin
          state_n = LOAD;
          song_n  = song_dec;
        end else if (play_button) state_n = PAUSE;
      PAUSE:
        if (play_button) state_n = PLAY;
        else if (next_button) begin
          state_n = LOAD;
          song_n  = song_inc;
        end else if (prev_button) begin
          state_n = LOAD;
          song_n  = song_dec;
        end
      GAP:
        if (next_button) begin
          state_n = LOAD;
          song_n  = song_inc;
        end else if (prev_button) begin
          state_n = LOAD;
          song_n  = song_dec;
        end else if (cnt == '0) begin
          state_n = (song == LAST && !loop_en) ? IDLE : LOAD;
          song_n  = song_inc;
          end_n   = song == LAST && !loop_en;
        end else cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // outputs decode the next state so they are registered alongside it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      song         <= '0;
      cnt          <= '0;
      play         <= 1'b0;
      reset_player <= 1'b0;
      list_end     <= 1'b0;
    end else begin
      state        <= state_n;
      song         <= song_n;
      cnt          <= cnt_n;
      play         <= state_n == PLAY;
      reset_player <= state_n == LOAD;
      list_end     <= end_n;
    end
endmodule

// File: tb/tb_playlist_sequencer.sv
// tb_playlist_sequencer: directed stimulus with an event scoreboard for playlist_sequencer
module tb_playlist_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_button = 1'b0;
  logic       next_button = 1'b0;
  logic       prev_button = 1'b0;
  logic       loop_en = 1'b0;
  logic       song_done = 1'b0;
  logic       play, reset_player, list_end;
  logic [1:0] song;
  typedef struct {int k; int s; int c;} ev_t;
  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  t;
  logic prev_play = 1'b0;
  localparam int P = 1, N = 2, V = 4, D = 8;
  localparam int KF = 0, KL = 1, KR = 2, KE = 3;
  playlist_sequencer dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .loop_en(loop_en), .song_done(song_done),
    .play(play), .reset_player(reset_player), .song(song), .list_end(list_end)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic see(input int k, input int s);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected event kind=%0d song=%0d cyc=%0d", k, s, cyc);
    end else begin
      e = q.pop_front();
      total++;
      if (e.k != k || e.s != s || e.c != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d song=%0d cyc=%0d expected kind=%0d song=%0d cyc=%0d",
                 k, s, cyc, e.k, e.s, e.c);
      end
    end
  endtask
  // events within one sample are checked in the fixed order F, L, R, E
  always @(negedge clk)
    if (!reset) prev_play <= 1'b0;
    else begin
      if (!play && prev_play) see(KF, int'(song));
      if (reset_player) see(KL, int'(song));
      if (play && !prev_play) see(KR, int'(song));
      if (list_end) see(KE, int'(song));
      prev_play <= play;
    end
  function automatic void ex(input int k, input int s, input int c);
    q.push_back('{k, s, c});
  endfunction
  task automatic pulse(input int m, output int tc);
    @(negedge clk);
    play_button = m[0];
    next_button = m[1];
    prev_button = m[2];
    song_done   = m[3];
    @(posedge clk);
    #1;
    {play_button, next_button, prev_button, song_done} = 4'b0;
    tc = cyc;
  endtask
  task automatic waitc(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic skip(input int s);
    pulse(N, t); ex(KF, s, t); ex(KL, s, t); ex(KR, s, t + 1);
    waitc(3);
  endtask
  task automatic chk_reset(input string name);
    chk({name, "_play"}, int'(play), 0);
    chk({name, "_rp"}, int'(reset_player), 0);
    chk({name, "_song"}, int'(song), 0);
    chk({name, "_end"}, int'(list_end), 0);
  endtask
  initial begin
    waitc(3);
    #1 chk_reset("por");
    @(negedge clk) reset = 1'b1;
    waitc(2);
    pulse(P, t); ex(KL, 0, t); ex(KR, 0, t + 1);
    waitc(3);
    pulse(D, t); ex(KF, 0, t); ex(KL, 1, t + 8); ex(KR, 1, t + 9);
    waitc(12);
    skip(2);
    skip(3);
    pulse(D, t); ex(KF, 3, t); ex(KE, 0, t + 8);
    waitc(12);
    loop_en = 1'b1;
    pulse(P, t); ex(KL, 0, t); ex(KR, 0, t + 1);
    waitc(3);
    skip(1);
    skip(2);
    skip(3);
    pulse(D, t); ex(KF, 3, t); ex(KL, 0, t + 8); ex(KR, 0, t + 9);
    waitc(12);
    loop_en = 1'b0;
    pulse(P, t); ex(KF, 0, t);
    waitc(2);
    pulse(P, t); ex(KR, 0, t);
    waitc(2);
    pulse(V, t); ex(KF, 3, t); ex(KL, 3, t); ex(KR, 3, t + 1);
    waitc(3);
    pulse(D | N, t); ex(KF, 3, t);
    waitc(2);
    pulse(N, t); ex(KL, 0, t); ex(KR, 0, t + 1);
    waitc(3);
    pulse(P, t); ex(KF, 0, t);
    waitc(2);
    pulse(N, t); ex(KL, 1, t); ex(KR, 1, t + 1);
    waitc(3);
    pulse(D, t); ex(KF, 1, t);
    waitc(3);
    @(posedge clk) #3 reset = 1'b0;
    #1 chk_reset("rst_gap");
    @(posedge clk) #2 reset = 1'b1;
    waitc(2);
    pulse(P, t); ex(KL, 0, t); ex(KR, 0, t + 1);
    waitc(3);
    skip(1);
    @(posedge clk) #4 reset = 1'b0;
    #1 chk_reset("rst_play");
    @(posedge clk) #3 reset = 1'b1;
    waitc(2);
    pulse(P, t); ex(KL, 0, t); ex(KR, 0, t + 1);
    waitc(5);
    chk("pending_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
